// File: rtl/uart_pkg.sv
// Shared types for the UART receive controller.
// States, FIFO entry layout and parity-type codes.
package uart_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    IDLE     = 2'd1,
    BUSY     = 2'd2
  } state_t;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } entry_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO for captured UART frames.
// Head reads as zero while empty so outputs are clean after reset.
module uart_rx_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 10,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rp];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud16 tick, parity config,
// frame capture FIFO and saturating error statistics.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter  int DIV_W      = 16,
  parameter  int FIFO_DEPTH = 8,
  parameter  int CNT_W      = 8,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_wr,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_par_en,
  input  logic             cfg_par_ty,
  input  logic             rx,
  input  logic             rx_done_i,
  input  logic [7:0]       rx_data_i,
  input  logic             parity_err_i,
  input  logic             framing_err_i,
  output logic             baud16_tick,
  output logic             par_en,
  output logic             par_ty,
  output logic [7:0]       m_data,
  output logic             m_perr,
  output logic             m_ferr,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CW-1:0]    fifo_count,
  output logic             overrun,
  output logic [CNT_W-1:0] perr_cnt,
  output logic [CNT_W-1:0] ferr_cnt,
  input  logic             stat_clr
);

  state_t           state;
  state_t           state_n;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] shd_div;
  logic             shd_pen;
  logic             shd_pty;
  logic             pending;
  logic             apply;
  logic             done_q;
  logic             rise;
  logic             push_q;
  entry_t           entry_q;
  entry_t           head;
  logic             full;
  logic             empty;

  assign apply = pending & (state == IDLE || state == DISABLED);
  assign rise  = rx_done_i & ~done_q;

  // Baud16 divider: free-runs 0..div_act while enabled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      baud16_tick <= 1'b0;
    end else if (!en || apply) begin
      cnt         <= '0;
      baud16_tick <= 1'b0;
    end else if (cnt == div_act) begin
      cnt         <= '0;
      baud16_tick <= 1'b1;
    end else begin
      cnt         <= cnt + 1'b1;
      baud16_tick <= 1'b0;
    end
  end

  // Shadow config, applied to the receiver only between frames.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shd_div <= '0;
      shd_pen <= 1'b0;
      shd_pty <= PAR_EVEN;
      pending <= 1'b0;
      div_act <= '0;
      par_en  <= 1'b0;
      par_ty  <= PAR_EVEN;
    end else begin
      if (apply) begin
        div_act <= shd_div;
        par_en  <= shd_pen;
        par_ty  <= shd_pty;
      end
      if (cfg_wr) begin
        shd_div <= cfg_div;
        shd_pen <= cfg_par_en;
        shd_pty <= cfg_par_ty;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= DISABLED;
    else      state <= state_n;
  end

  // Next-state: start bit seen on a tick, done edge ends frame.
  always_comb begin
    state_n = state;
    if (!en) begin
      state_n = DISABLED;
    end else begin
      case (state)
        DISABLED: state_n = IDLE;
        IDLE:     if (baud16_tick && !rx) state_n = BUSY;
        BUSY:     if (rise) state_n = IDLE;
        default:  state_n = DISABLED;
      endcase
    end
  end

  // Frame capture; done_q resets high so a level still
  // asserted across reset is not taken as a new frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      done_q  <= 1'b1;
      push_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      done_q  <= rx_done_i;
      push_q  <= rise;
      if (rise) begin
        entry_q.ferr <= framing_err_i;
        entry_q.perr <= parity_err_i;
        entry_q.data <= rx_data_i;
      end
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (10)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .pop   (m_ready),
    .wdata (entry_q),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign m_valid = ~empty;
  assign m_data  = head.data;
  assign m_perr  = head.perr;
  assign m_ferr  = head.ferr;

  // Sticky overrun and saturating error counters; clear wins.
  always_ff @(posedge clk) begin
    if (!rst || stat_clr) begin
      overrun  <= 1'b0;
      perr_cnt <= '0;
      ferr_cnt <= '0;
    end else if (push_q) begin
      if (full && !(m_ready && m_valid)) overrun <= 1'b1;
      if (entry_q.perr && !(&perr_cnt)) perr_cnt <= perr_cnt + 1'b1;
      if (entry_q.ferr && !(&ferr_cnt)) ferr_cnt <= ferr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl.
// Expected values are hand-derived per scenario.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cfg_wr;
  logic [15:0] cfg_div;
  logic        cfg_par_en;
  logic        cfg_par_ty;
  logic        rx;
  logic        rx_done_i;
  logic [7:0]  rx_data_i;
  logic        parity_err_i;
  logic        framing_err_i;
  logic        baud16_tick;
  logic        par_en;
  logic        par_ty;
  logic [7:0]  m_data;
  logic        m_perr;
  logic        m_ferr;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  fifo_count;
  logic        overrun;
  logic [7:0]  perr_cnt;
  logic [7:0]  ferr_cnt;
  logic        stat_clr;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .cfg_wr        (cfg_wr),
    .cfg_div       (cfg_div),
    .cfg_par_en    (cfg_par_en),
    .cfg_par_ty    (cfg_par_ty),
    .rx            (rx),
    .rx_done_i     (rx_done_i),
    .rx_data_i     (rx_data_i),
    .parity_err_i  (parity_err_i),
    .framing_err_i (framing_err_i),
    .baud16_tick   (baud16_tick),
    .par_en        (par_en),
    .par_ty        (par_ty),
    .m_data        (m_data),
    .m_perr        (m_perr),
    .m_ferr        (m_ferr),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .fifo_count    (fifo_count),
    .overrun       (overrun),
    .perr_cnt      (perr_cnt),
    .ferr_cnt      (ferr_cnt),
    .stat_clr      (stat_clr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] d,
                       input logic p,
                       input logic f);
    rx_done_i     = 1'b1;
    rx_data_i     = d;
    parity_err_i  = p;
    framing_err_i = f;
    step();
    rx_done_i = 1'b0;
    step();
  endtask

  int nticks;
  int first;
  int last;
  int bad;

  initial begin
    rst = 1'b0; en = 1'b0; cfg_wr = 1'b0; cfg_div = '0;
    cfg_par_en = 1'b0; cfg_par_ty = 1'b0; rx = 1'b1;
    rx_done_i = 1'b0; rx_data_i = '0; parity_err_i = 1'b0;
    framing_err_i = 1'b0; m_ready = 1'b0; stat_clr = 1'b0;
    step(); step();

    chk("rst_tick", baud16_tick, 0);
    chk("rst_paren", par_en, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_perr", perr_cnt, 0);
    chk("rst_ferr", ferr_cnt, 0);
    chk("rst_data", m_data, 0);

    // divisor 3 applied while disabled
    rst = 1'b1;
    cfg_wr = 1'b1; cfg_div = 16'd3;
    step();
    cfg_wr = 1'b0;
    step();
    en = 1'b1;
    nticks = 0; first = 0; last = 0; bad = 0;
    for (int i = 1; i <= 42; i++) begin
      step();
      if (baud16_tick) begin
        if (nticks == 0) first = i;
        else if (i - last != 4) bad++;
        last = i;
        nticks++;
      end
    end
    chk("tick_first", first, 4);
    chk("tick_n", nticks, 10);
    chk("tick_gap", bad, 0);

    en = 1'b0;
    nticks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (baud16_tick) nticks++;
    end
    chk("tick_off", nticks, 0);

    en = 1'b1;
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (baud16_tick && first == 0) first = i;
    end
    chk("tick_restart", first, 4);

    // enter BUSY, write parity config mid-frame
    rx = 1'b0;
    repeat (8) step();
    rx = 1'b1;
    cfg_wr = 1'b1; cfg_par_en = 1'b1; cfg_par_ty = 1'b1;
    step();
    cfg_wr = 1'b0;
    repeat (4) step();
    chk("busy_paren", par_en, 0);

    rx_done_i = 1'b1; rx_data_i = 8'hA5;
    step();
    chk("lat1_valid", m_valid, 0);
    chk("lat1_paren", par_en, 0);
    step();
    chk("lat2_valid", m_valid, 1);
    chk("lat2_data", m_data, 8'hA5);
    chk("apply_paren", par_en, 1);
    chk("apply_party", par_ty, 1);
    repeat (3) step();
    rx_done_i = 1'b0;
    step();
    chk("level_once", fifo_count, 1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("pop_empty", m_valid, 0);

    // overflow: 9 frames into depth 8
    for (int i = 0; i < 9; i++)
      frame(8'(8'h10 + i), 1'b0, i == 2);
    step(); step();
    chk("ovf_count", fifo_count, 8);
    chk("ovf_flag", overrun, 1);
    chk("ovf_ferr_cnt", ferr_cnt, 1);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_order", m_data, 32'(8'h10 + i));
      chk("ovf_fflag", m_ferr, (i == 2) ? 1 : 0);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
    end
    chk("ovf_lost9", m_valid, 0);

    // push and pop together on empty
    m_ready = 1'b1;
    frame(8'h5A, 1'b1, 1'b0);
    chk("emp_pp_valid", m_valid, 1);
    chk("emp_pp_data", m_data, 8'h5A);
    chk("emp_pp_perr", m_perr, 1);
    step();
    chk("emp_pp_drain", m_valid, 0);

    // parity counter saturation
    for (int i = 0; i < 300; i++)
      frame(8'(i), 1'b1, 1'b0);
    step(); step();
    chk("sat_perr", perr_cnt, 255);
    chk("sat_ovr", overrun, 1);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("clr_perr", perr_cnt, 0);
    chk("clr_ferr", ferr_cnt, 0);
    chk("clr_ovr", overrun, 0);

    // clear coincident with increment
    rx_done_i = 1'b1; parity_err_i = 1'b1;
    step();
    rx_done_i = 1'b0; stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("clr_wins", perr_cnt, 0);
    step();
    m_ready = 1'b0;
    parity_err_i = 1'b0;

    // reset mid-frame with 3 bytes queued
    for (int i = 0; i < 3; i++)
      frame(8'(8'h40 + i), 1'b0, 1'b0);
    step();
    chk("pre_rst_count", fifo_count, 3);
    rx = 1'b0;
    repeat (8) step();
    rx = 1'b1;
    rst = 1'b0; rx_done_i = 1'b1;
    step();
    rst = 1'b1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_paren", par_en, 0);
    repeat (3) step();
    chk("post_rst_ignore", fifo_count, 0);
    rx_done_i = 1'b0;
    step();
    frame(8'h3C, 1'b0, 1'b0);
    chk("post_rst_count", fifo_count, 1);
    chk("post_rst_data", m_data, 8'h3C);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
